// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access type codes,
// controller state encoding and per-type access width/byte-mask helpers.
package dm_ctrl_pkg;

    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPLIT  = 2'd1,
        ST_OUTREG = 2'd2,
        ST_RESP   = 2'd3
    } dm_state_e;

    // Access size in bytes; illegal codes report 1 so they never look misaligned.
    function automatic logic [2:0] dm_width(input logic [2:0] typ);
        logic [2:0] w;
        case (typ)
            DM_WORD:                           w = 3'd4;
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: w = 3'd2;
            default:                           w = 3'd1;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] dm_mask(input logic [2:0] typ);
        logic [3:0] m;
        case (dm_width(typ))
            3'd4:    m = 4'b1111;
            3'd2:    m = 4'b0011;
            default: m = 4'b0001;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dm_ctrl_lane_ext.sv
// Combinational load extraction: shifts the two-word window by the byte offset
// and sign/zero-extends the selected byte or halfword.
module dm_lane_ext
    import dm_ctrl_pkg::*;
(
    input  logic [63:0] lanes_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  type_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = 32'(lanes_i >> {off_i, 3'b000});

    always_comb begin
        data_o = shifted;
        case (type_i)
            DM_BYTE:              data_o = {{24{shifted[7]}}, shifted[7:0]};
            DM_BYTE_UNSIGNED:     data_o = {24'b0, shifted[7:0]};
            DM_HALFWORD:          data_o = {{16{shifted[15]}}, shifted[15:0]};
            DM_HALFWORD_UNSIGNED: data_o = {16'b0, shifted[15:0]};
            default:              data_o = shifted;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// MEM-stage data-memory controller: one request outstanding, registered response
// 1 cycle after accept (+1 for a split access, +1 for REG_OUT loads); req_ready only in IDLE.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS    = 1024,
    parameter int MISALIGN_SPLIT = 1,
    parameter int REG_OUT        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_type_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    dm_state_e     state_q;
    logic          ready_q;
    logic          busy_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_rdata_q;
    logic [31:0]   stage_q;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic [2:0]    type_q;
    logic          we_q;
    logic [3:0]    hi_be_q;
    logic [31:0]   hi_dat_q;

    logic          accept;
    logic [AW-1:0] req_idx;
    logic [1:0]    req_off;
    logic [2:0]    req_width;
    logic          in_range;
    logic          type_ok;
    logic          misalign;
    logic          split_oob;
    logic          req_err;
    logic          do_split;
    logic [7:0]    be8;
    logic [63:0]   wdat64;

    assign accept    = req_valid_i & ready_q;
    assign req_idx   = req_addr_i[AW+1:2];
    assign req_off   = req_addr_i[1:0];
    assign req_width = dm_width(req_type_i);
    assign in_range  = (req_addr_i[31:AW+2] == '0);
    assign type_ok   = (req_type_i <= DM_BYTE_UNSIGNED);
    assign misalign  = ((req_width == 3'd2) && (req_off == 2'd3)) ||
                       ((req_width == 3'd4) && (req_off != 2'd0));
    // The second word of a split access would fall off the end of the array.
    assign split_oob = &req_idx;
    assign req_err   = !in_range || !type_ok ||
                       (misalign && (MISALIGN_SPLIT == 0)) ||
                       (misalign && split_oob);
    assign do_split  = misalign && !req_err;
    assign be8       = {4'b0, dm_mask(req_type_i)} << req_off;
    assign wdat64    = {32'b0, req_wdata_i} << {req_off, 3'b000};

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_dat;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = req_idx;
        wr_be  = be8[3:0];
        wr_dat = wdat64[31:0];
        if (state_q == ST_SPLIT) begin
            wr_en  = we_q;
            wr_idx = idx_q + AW'(1);
            wr_be  = hi_be_q;
            wr_dat = hi_dat_q;
        end else if (accept && req_we_i && !req_err) begin
            wr_en  = 1'b1;
        end
    end

    // Gating with rst keeps an interrupted split store from touching word k+1.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    logic [AW-1:0] rd_idx;
    logic [1:0]    rd_off;
    logic [2:0]    rd_type;
    logic [63:0]   rd_lanes;
    logic [31:0]   ld_data;

    assign rd_idx   = (state_q == ST_SPLIT) ? idx_q  : req_idx;
    assign rd_off   = (state_q == ST_SPLIT) ? off_q  : req_off;
    assign rd_type  = (state_q == ST_SPLIT) ? type_q : req_type_i;
    assign rd_lanes = {mem[rd_idx + AW'(1)], mem[rd_idx]};

    dm_lane_ext u_lane_ext (
        .lanes_i (rd_lanes),
        .off_i   (rd_off),
        .type_i  (rd_type),
        .data_o  (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            stage_q      <= '0;
            idx_q        <= '0;
            off_q        <= '0;
            type_q       <= '0;
            we_q         <= 1'b0;
            hi_be_q      <= '0;
            hi_dat_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        idx_q    <= req_idx;
                        off_q    <= req_off;
                        type_q   <= req_type_i;
                        we_q     <= req_we_i;
                        hi_be_q  <= be8[7:4];
                        hi_dat_q <= wdat64[63:32];
                        if (req_err) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (do_split) begin
                            state_q <= ST_SPLIT;
                        end else if (!req_we_i && (REG_OUT != 0)) begin
                            stage_q <= ld_data;
                            state_q <= ST_OUTREG;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= req_we_i ? 32'b0 : ld_data;
                        end
                    end
                end
                ST_SPLIT: begin
                    if (!we_q && (REG_OUT != 0)) begin
                        stage_q <= ld_data;
                        state_q <= ST_OUTREG;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? 32'b0 : ld_data;
                    end
                end
                ST_OUTREG: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= stage_q;
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b0;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign busy_o       = busy_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: dut0 splits misaligned accesses (REG_OUT=0, 1024 words),
// dut1 rejects them (REG_OUT=1, 16 words).
module tb_dm_ctrl;
    import dm_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_err;
    logic [1:0]  busy;
    logic [2:0]  req_type   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [31:0] resp_rdata [2];

    always #5 clk = ~clk;

    dm_ctrl #(.DEPTH_WORDS(1024), .MISALIGN_SPLIT(1), .REG_OUT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_type_i(req_type[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .resp_valid_o(resp_valid[0]), .resp_rdata_o(resp_rdata[0]),
        .resp_err_o(resp_err[0]), .busy_o(busy[0])
    );

    dm_ctrl #(.DEPTH_WORDS(16), .MISALIGN_SPLIT(0), .REG_OUT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_type_i(req_type[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .resp_valid_o(resp_valid[1]), .resp_rdata_o(resp_rdata[1]),
        .resp_err_o(resp_err[1]), .busy_o(busy[1])
    );

    logic [63:0] lx_lanes;
    logic [1:0]  lx_off;
    logic [2:0]  lx_type;
    logic [31:0] lx_data;

    dm_lane_ext u_lx (.lanes_i(lx_lanes), .off_i(lx_off), .type_i(lx_type), .data_o(lx_data));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        int          tag;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   tag_q       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response pulse; latency counted in edges from accept.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (resp_valid[d]) begin : mon
                exp_t e;
                bit   have;
                have = 1'b0;
                if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
                if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
                if (!have) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dut%0d unexpected response: rdata %h err %b", d, resp_rdata[d], resp_err[d]);
                end else begin
                    check($sformatf("dut%0d v%0d rdata", d, e.tag), resp_rdata[d], e.rdata);
                    check($sformatf("dut%0d v%0d err", d, e.tag), 32'(resp_err[d]), 32'(e.err));
                    check($sformatf("dut%0d v%0d latency", d, e.tag), 32'(cyc + 1 - e.acc), 32'(e.lat));
                    check($sformatf("dut%0d v%0d ready_in_resp", d, e.tag), 32'(req_ready[d]), 32'd0);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic do_req(input int d, input bit we, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err,
                          input int lat, input bit keep, input bit track);
        exp_t e;
        int   n;
        req_we[d]    = we;
        req_type[d]  = typ;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        tag_q++;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d v%0d accept timeout: req_ready stuck %b, required 1", d, tag_q, req_ready[d]);
            req_valid[d] = 1'b0;
            return;
        end
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.acc   = cyc + 1;
        e.lat   = lat;
        e.tag   = tag_q;
        if (track) begin
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(negedge clk);
        if (!keep) req_valid[d] = 1'b0;
    endtask

    task automatic ld(input int d, input logic [2:0] typ, input logic [31:0] addr,
                      input logic [31:0] exp_rd, input bit exp_err, input int lat);
        do_req(d, 1'b0, typ, addr, 32'h0, exp_rd, exp_err, lat, 1'b0, 1'b1);
    endtask

    task automatic st(input int d, input logic [2:0] typ, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit exp_err, input int lat);
        do_req(d, 1'b1, typ, addr, wdata, 32'h0, exp_err, lat, 1'b0, 1'b1);
    endtask

    task automatic lx(input logic [1:0] off, input logic [2:0] typ, input logic [31:0] exp);
        lx_lanes = 64'h5566_7788_99AA_BBCC;
        lx_off   = off;
        lx_type  = typ;
        #1;
        check($sformatf("lane_ext off%0d type%0d", off, typ), lx_data, exp);
    endtask

    task automatic busy_len(input int d, input int exp);
        int n;
        n = 0;
        while (busy[d] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("dut%0d busy cycles", d), 32'(n), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        req_we    = '0;
        for (int d = 0; d < 2; d++) begin
            req_type[d]  = '0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
        end

        lx(2'd1, DM_BYTE,              32'hFFFF_FFBB);
        lx(2'd2, DM_BYTE_UNSIGNED,     32'h0000_00AA);
        lx(2'd3, DM_HALFWORD,          32'hFFFF_8899);
        lx(2'd3, DM_WORD,              32'h6677_8899);

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d rst resp_valid", d), 32'(resp_valid[d]), 32'd0);
            check($sformatf("dut%0d rst resp_rdata", d), resp_rdata[d], 32'd0);
            check($sformatf("dut%0d rst resp_err", d), 32'(resp_err[d]), 32'd0);
            check($sformatf("dut%0d rst busy", d), 32'(busy[d]), 32'd0);
            check($sformatf("dut%0d rst req_ready", d), 32'(req_ready[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("dut%0d ready after rst", d), 32'(req_ready[d]), 32'd1);

        // Extension of byte/halfword loads on both configurations.
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? 1 : 2;
            st(d, DM_WORD,              32'h10, 32'h8080_F0F1, 1'b0, 1);
            ld(d, DM_BYTE,              32'h10, 32'hFFFF_FFF1, 1'b0, lat);
            ld(d, DM_BYTE_UNSIGNED,     32'h13, 32'h0000_0080, 1'b0, lat);
            ld(d, DM_HALFWORD,          32'h12, 32'hFFFF_8080, 1'b0, lat);
            ld(d, DM_HALFWORD_UNSIGNED, 32'h10, 32'h0000_F0F1, 1'b0, lat);
            ld(d, DM_WORD,              32'h10, 32'h8080_F0F1, 1'b0, lat);
            ld(d, DM_HALFWORD,          32'h11, 32'hFFFF_80F0, 1'b0, lat);
        end

        // Split store/load across words 0x20 and 0x24.
        st(0, DM_WORD, 32'h20, 32'h1122_3344, 1'b0, 1);
        st(0, DM_WORD, 32'h24, 32'h5566_7788, 1'b0, 1);
        st(0, DM_WORD, 32'h21, 32'hAABB_CCDD, 1'b0, 2);
        busy_len(0, 2);
        ld(0, DM_WORD, 32'h21, 32'hAABB_CCDD, 1'b0, 2);
        busy_len(0, 2);
        ld(0, DM_WORD,          32'h20, 32'hBBCC_DD44, 1'b0, 1);
        ld(0, DM_WORD,          32'h24, 32'h5566_77AA, 1'b0, 1);
        ld(0, DM_HALFWORD,      32'h23, 32'hFFFF_AABB, 1'b0, 2);
        ld(0, DM_BYTE_UNSIGNED, 32'h27, 32'h0000_0055, 1'b0, 1);

        // Misaligned accesses rejected when splitting is disabled.
        st(1, DM_WORD,              32'h20, 32'h1122_3344, 1'b0, 1);
        ld(1, DM_HALFWORD,          32'h23, 32'h0,         1'b1, 1);
        st(1, DM_WORD,              32'h22, 32'hDEAD_BEEF, 1'b1, 1);
        st(1, DM_HALFWORD,          32'h23, 32'h0000_FFFF, 1'b1, 1);
        ld(1, DM_WORD,              32'h20, 32'h1122_3344, 1'b0, 2);
        ld(1, DM_HALFWORD_UNSIGNED, 32'h22, 32'h0000_1122, 1'b0, 2);

        // Range and illegal-type errors.
        st(0, DM_WORD,     32'hFFC,       32'h0BAD_F00D, 1'b0, 1);
        ld(0, DM_WORD,     32'h1000,      32'h0,         1'b1, 1);
        st(0, DM_WORD,     32'hFFE,       32'h1234_5678, 1'b1, 1);
        ld(0, DM_WORD,     32'hFFC,       32'h0BAD_F00D, 1'b0, 1);
        ld(0, DM_WORD,     32'hFFE,       32'h0,         1'b1, 1);
        ld(0, DM_HALFWORD, 32'hFFE,       32'h0000_0BAD, 1'b0, 1);
        ld(0, 3'b101,      32'h10,        32'h0,         1'b1, 1);
        st(0, 3'b111,      32'h10,        32'h0,         1'b1, 1);
        ld(0, DM_WORD,     32'h10,        32'h8080_F0F1, 1'b0, 1);
        ld(0, DM_WORD,     32'h8000_0010, 32'h0,         1'b1, 1);
        st(1, DM_WORD,     32'h3C,        32'h7F00_0000, 1'b0, 1);
        ld(1, DM_BYTE,     32'h3F,        32'h0000_007F, 1'b0, 2);
        ld(1, DM_WORD,     32'h40,        32'h0,         1'b1, 1);

        // Back-to-back requests with req_valid held high.
        do_req(0, 1'b1, DM_BYTE,              32'h30, 32'h1234_56A5, 32'h0,         1'b0, 1, 1'b1, 1'b1);
        do_req(0, 1'b1, DM_BYTE_UNSIGNED,     32'h31, 32'h9876_545A, 32'h0,         1'b0, 1, 1'b1, 1'b1);
        do_req(0, 1'b0, DM_HALFWORD_UNSIGNED, 32'h30, 32'h0,         32'h0000_5AA5, 1'b0, 1, 1'b1, 1'b1);
        do_req(0, 1'b0, DM_BYTE,              32'h30, 32'h0,         32'hFFFF_FFA5, 1'b0, 1, 1'b0, 1'b1);

        // Reset landing in the SPLIT cycle of a split store.
        st(0, DM_WORD, 32'h40, 32'h1111_1111, 1'b0, 1);
        st(0, DM_WORD, 32'h44, 32'h2222_2222, 1'b0, 1);
        do_req(0, 1'b1, DM_WORD, 32'h42, 32'hCAFE_BABE, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        check("split in progress busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("mid-split rst resp_valid", 32'(resp_valid[0]), 32'd0);
        check("mid-split rst busy", 32'(busy[0]), 32'd0);
        check("mid-split rst req_ready", 32'(req_ready[0]), 32'd0);
        check("mid-split rst resp_rdata", resp_rdata[0], 32'd0);
        check("mid-split rst resp_err", 32'(resp_err[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ld(0, DM_WORD, 32'h40, 32'hBABE_1111, 1'b0, 1);
        ld(0, DM_WORD, 32'h44, 32'h2222_2222, 1'b0, 1);

        for (int n = 0; n < 20 && (sb0.size() + sb1.size()) > 0; n++) @(negedge clk);
        while (sb0.size() > 0) begin
            exp_t e;
            e = sb0.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL dut0 v%0d missing response: got none, required rdata %h", e.tag, e.rdata);
        end
        while (sb1.size() > 0) begin
            exp_t e;
            e = sb1.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL dut1 v%0d missing response: got none, required rdata %h", e.tag, e.rdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
